sysbus16: RTL and testbench

Parametrised memory-map and I/O controller for the 16-bit CPU system. It decodes CPU addresses into RAM, ROM and I/O regions and steers the read-data mux with a one-cycle registered select, matched to the synchronous memories. It provides GPIO_CH banks of synchronised 16-bit inputs and registered outputs, and inserts ROM wait states through the CPU `hold` input. It also holds an optional interval timer with an interrupt output. It replaces the fixed switch/LED decode in the top-level system.

---
 rtl/sysbus16.sv | 183 ++++++++++++++++++
 tb/tb_sysbus16.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus16.sv
`default_nettype none
// ============================================================================
// sysbus16 : memory-map decode, read-data steering, GPIO banks, ROM wait states
//            and an optional interval timer (enabled by SYSBUS16_TIMER_EN).
// Revision  : 1.0
// ============================================================================
module sysbus16 #(
    parameter int          RAM_AW   = 12,
    parameter int          ROM_AW   = 12,
    parameter logic [15:0] IO_BASE  = 16'h2000,
    parameter int          GPIO_CH  = 2,
    parameter int          ROM_WAIT = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           cpu_addr,
    input  logic [15:0]           cpu_dout,
    input  logic                  cpu_we,
    output logic [15:0]           cpu_din,
    output logic                  hold,
    output logic                  ram_we,
    input  logic [15:0]           ram_dout,
    input  logic [15:0]           rom_dout,
    input  logic [16*GPIO_CH-1:0] gpio_in,
    output logic [16*GPIO_CH-1:0] gpio_out,
    output logic                  irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_ROM, SRC_IO} src_t;

    logic        ram_sel, rom_sel, io_sel, io_we;
    logic [15:0] io_off;

    always_comb begin
        io_off  = cpu_addr - IO_BASE;
        ram_sel = {16'd0, cpu_addr} < (32'd1 << RAM_AW);
        rom_sel = {16'd0, cpu_addr} >= (32'h0001_0000 - (32'd1 << ROM_AW));
        io_sel  = (io_off < 16'd32) && !ram_sel && !rom_sel;
    end

    // Wait-state FSM: hold spans exactly ROM_WAIT cycles, the detect cycle included.
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        hold_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rom_sel && (ROM_WAIT > 0)) begin
                    hold_c  = 1'b1;
                    cnt_d   = 4'(ROM_WAIT - 1);
                    state_d = (ROM_WAIT == 1) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                hold_c = 1'b1;
                if (cnt_q <= 4'd1) state_d = ST_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign hold   = hold_c & reset_n;
    assign ram_we = cpu_we & ram_sel & ~hold;
    assign io_we  = cpu_we & io_sel & ~hold;

    // GPIO banks and input synchronisers
    logic [16*GPIO_CH-1:0] gpio_q, gpio_d, sync1_q, sync2_q;

    always_comb begin
        gpio_d = gpio_q;
        for (int k = 0; k < GPIO_CH; k++) begin
            if (io_we && (io_off[4:0] == 5'(2*k + 1))) gpio_d[16*k +: 16] = cpu_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gpio_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            gpio_q  <= gpio_d;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

    assign gpio_out = gpio_q;

`ifdef SYSBUS16_TIMER_EN
    logic [15:0] tcnt_q, tper_q;
    logic        ten_q, tie_q, tflag_q, t_expire;

    assign t_expire = ten_q && (tcnt_q == 16'd0);

    // Later assignments take priority: a count write beats reload, expiry beats clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tcnt_q  <= '0;
            tper_q  <= '0;
            ten_q   <= 1'b0;
            tie_q   <= 1'b0;
            tflag_q <= 1'b0;
        end else begin
            if (t_expire)   tcnt_q <= tper_q;
            else if (ten_q) tcnt_q <= tcnt_q - 16'd1;
            if (io_we && io_off[4:0] == 5'h10) tcnt_q <= cpu_dout;
            if (io_we && io_off[4:0] == 5'h11) tper_q <= cpu_dout;
            if (io_we && io_off[4:0] == 5'h12) begin
                ten_q <= cpu_dout[0];
                tie_q <= cpu_dout[1];
                if (cpu_dout[15]) tflag_q <= 1'b0;
            end
            if (t_expire) tflag_q <= 1'b1;
        end
    end

    assign irq = tflag_q & tie_q;
`else
    assign irq = 1'b0;
`endif

    // Read-select and captured IO data advance together whenever hold is low
    src_t        src_q, src_d;
    logic [15:0] io_rd_q, io_rd_d;

    always_comb begin
        src_d = SRC_NONE;
        if (ram_sel)      src_d = SRC_RAM;
        else if (rom_sel) src_d = SRC_ROM;
        else if (io_sel)  src_d = SRC_IO;

        io_rd_d = '0;
        for (int k = 0; k < GPIO_CH; k++) begin
            if (!io_off[4] && (io_off[3:1] == 3'(k)))
                io_rd_d = io_off[0] ? gpio_q[16*k +: 16] : sync2_q[16*k +: 16];
        end
`ifdef SYSBUS16_TIMER_EN
        if (io_off[4:0] == 5'h10) io_rd_d = tcnt_q;
        if (io_off[4:0] == 5'h11) io_rd_d = tper_q;
        if (io_off[4:0] == 5'h12) io_rd_d = {tflag_q, 13'd0, tie_q, ten_q};
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_q   <= SRC_NONE;
            io_rd_q <= '0;
        end else if (!hold) begin
            src_q   <= src_d;
            io_rd_q <= io_rd_d;
        end
    end

    always_comb begin
        cpu_din = '0;
        case (src_q)
            SRC_RAM: cpu_din = ram_dout;
            SRC_ROM: cpu_din = rom_dout;
            SRC_IO:  cpu_din = io_rd_q;
            default: cpu_din = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sysbus16.sv
`default_nettype none
// ============================================================================
// tb_sysbus16 : randomized scoreboard bench for sysbus16 (ROM_WAIT=3, plus a
//               ROM_WAIT=0 instance that must never raise hold).
// Revision    : 1.0
// ============================================================================
module tb_sysbus16;
    localparam int          RAM_AW   = 12;
    localparam int          ROM_AW   = 12;
    localparam logic [15:0] IO_BASE  = 16'h2000;
    localparam int          GPIO_CH  = 2;
    localparam int          GW       = 16 * GPIO_CH;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [15:0]   cpu_addr = 16'h3000, cpu_dout = 16'h0;
    logic          cpu_we = 1'b0;
    logic [15:0]   cpu_din, ram_dout, rom_dout, cpu_din0;
    logic          hold, ram_we, irq, hold0, ram_we0, irq0;
    logic [GW-1:0] gpio_in = '0, gpio_out, gpio_out0;

    sysbus16 #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW), .IO_BASE(IO_BASE),
               .GPIO_CH(GPIO_CH), .ROM_WAIT(3)) u_dut (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_we(cpu_we), .cpu_din(cpu_din), .hold(hold), .ram_we(ram_we),
        .ram_dout(ram_dout), .rom_dout(rom_dout), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .irq(irq));

    sysbus16 #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW), .IO_BASE(IO_BASE),
               .GPIO_CH(GPIO_CH), .ROM_WAIT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_we(cpu_we), .cpu_din(cpu_din0), .hold(hold0), .ram_we(ram_we0),
        .ram_dout(ram_dout), .rom_dout(rom_dout), .gpio_in(gpio_in),
        .gpio_out(gpio_out0), .irq(irq0));

    always #5 clk = ~clk;

    // Synchronous memories: read-first RAM, ROM contents = address ^ 5A5A
    bit [15:0] mem [1 << RAM_AW];
    always @(posedge clk) begin
        if (ram_we) mem[cpu_addr[RAM_AW-1:0]] <= cpu_dout;
        ram_dout <= mem[cpu_addr[RAM_AW-1:0]];
        rom_dout <= cpu_addr ^ 16'h5A5A;
    end

    int        checks = 0, errors = 0, hold0_hi = 0;
    bit [15:0] exp_q[$];
    bit        issuing = 1'b0, acc_flag = 1'b0;
    bit [15:0] ref_ram [1 << RAM_AW];
    bit [15:0] gout_m [GPIO_CH];
    bit [15:0] gin_m  [GPIO_CH];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        int off;
        off = int'(a) - int'(IO_BASE);
        if (int'(a) < (1 << RAM_AW))            return ref_ram[a[RAM_AW-1:0]];
        if (int'(a) >= 65536 - (1 << ROM_AW))   return a ^ 16'h5A5A;
        if (off >= 0 && off < 2 * GPIO_CH)      return (off % 2 == 1) ? gout_m[off/2] : gin_m[off/2];
        return 16'h0000;
    endfunction

    task automatic model_wr(input logic [15:0] a, input logic [15:0] d);
        int off;
        off = int'(a) - int'(IO_BASE);
        if (int'(a) < (1 << RAM_AW)) ref_ram[a[RAM_AW-1:0]] = d;
        else if (off >= 0 && off < 2 * GPIO_CH && off % 2 == 1) gout_m[off/2] = d;
    endtask

    function automatic logic [GW-1:0] gout_vec();
        logic [GW-1:0] v;
        for (int k = 0; k < GPIO_CH; k++) v[16*k +: 16] = gout_m[k];
        return v;
    endfunction

    // Monitor: one read result is due the cycle after every accepted access
    always @(negedge clk) begin : monitor
        bit [15:0] e;
        if (acc_flag) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_underflow got %h want none", cpu_din);
            end else begin
                e = exp_q.pop_front();
                if (cpu_din !== e) begin
                    errors++;
                    $display("FAIL rd_data got %h want %h", cpu_din, e);
                end
            end
        end
        acc_flag = issuing && !hold && reset_n;
        if (hold0) hold0_hi++;
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic access(input logic [15:0] a, input logic w, input logic [15:0] d,
                          input bit use_x, input logic [15:0] xv,
                          output int hc, output logic we_seen);
        bit acc;
        int n;
        cpu_addr = a; cpu_we = w; cpu_dout = d; issuing = 1'b1;
        exp_q.push_back(use_x ? xv : model_rd(a));
        hc = 0; we_seen = 1'b0; acc = 1'b0; n = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = !hold;
            if (hold) hc++;
            we_seen = ram_we;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 32'(n), 32'd0);
        if (acc && w) model_wr(a, d);
        cpu_we = 1'b0; cpu_addr = 16'h3000; issuing = 1'b0;
        chk("gpio_out_model", gpio_out, gout_vec());
    endtask

    task automatic acc(input logic [15:0] a, input logic w, input logic [15:0] d);
        int hc; logic ws;
        access(a, w, d, 1'b0, 16'h0, hc, ws);
    endtask

    task automatic accx(input logic [15:0] a, input logic w, input logic [15:0] d, input logic [15:0] xv);
        int hc; logic ws;
        access(a, w, d, 1'b1, xv, hc, ws);
    endtask

    function automatic logic [15:0] rand_addr();
        int r, off;
        r = int'($urandom_range(0, 3));
        case (r)
            0: return ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4095)) : 16'($urandom_range(0, 31));
            1: return 16'hF000 + 16'($urandom_range(0, 4095));
            2: begin
                off = int'($urandom_range(0, 31));
`ifdef SYSBUS16_TIMER_EN
                if (off >= 16 && off <= 18) off = 19;
`endif
                return IO_BASE + 16'(off);
            end
            default: return ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h1000, 16'h1FFF))
                                                        : 16'($urandom_range(16'h2020, 16'hEFFF));
        endcase
    endfunction

    initial begin : stim
        int   hc, irq_hi;
        logic ws;

        // Reset with a ROM address present: hold must stay low during reset
        cpu_addr = 16'hF123;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gpio_out", gpio_out, '0);
        chk("rst_cpu_din", cpu_din, 16'h0);
        chk("rst_hold", hold, 1'b0);
        chk("rst_irq", irq, 1'b0);
        cpu_addr = 16'h3000;
        reset_n  = 1'b1;
        @(posedge clk); #1;

        // GPIO round trip
        acc(IO_BASE + 16'd1, 1'b1, 16'hA5A5);
        chk("gpio_out_a5a5", gpio_out[15:0], 16'hA5A5);
        accx(IO_BASE + 16'd1, 1'b0, 16'h0, 16'hA5A5);
        gpio_in[31:16] = 16'h1234; gin_m[1] = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        accx(IO_BASE + 16'd2, 1'b0, 16'h0, 16'h1234);

        // Synchroniser depth: reads on the 1st and 2nd edges still see the old value
        gpio_in[15:0] = 16'hBEEF;
        accx(IO_BASE, 1'b0, 16'h0, 16'h0000);
        accx(IO_BASE, 1'b0, 16'h0, 16'h0000);
        accx(IO_BASE, 1'b0, 16'h0, 16'hBEEF);
        gin_m[0] = 16'hBEEF;

        // ROM wait states
        access(16'hF000, 1'b0, 16'h0, 1'b0, 16'h0, hc, ws);
        chk("rom_hold_cycles", 32'(hc), 32'd3);

        // RAM write pulse and read back
        access(16'h0010, 1'b1, 16'h0042, 1'b0, 16'h0, hc, ws);
        chk("ram_we_pulse", ws, 1'b1);
        @(negedge clk);
        chk("ram_we_low", ram_we, 1'b0);
        @(posedge clk); #1;
        accx(16'h0010, 1'b0, 16'h0, 16'h0042);

        // Unmapped accesses and RAM alias
        access(16'h3000, 1'b1, 16'hDEAD, 1'b0, 16'h0, hc, ws);
        chk("unmapped_no_we", ws, 1'b0);
        accx(16'h3000, 1'b0, 16'h0, 16'h0000);
        accx(16'h1010, 1'b0, 16'h0, 16'h0000);

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 49) begin
                gpio_in = GW'($urandom);
                for (int k = 0; k < GPIO_CH; k++) gin_m[k] = gpio_in[16*k +: 16];
                repeat (3) @(posedge clk);
                #1;
            end
            acc(rand_addr(), 1'($urandom_range(0, 1)), 16'($urandom));
        end

`ifdef SYSBUS16_TIMER_EN
        // Timer: period 4 and count 4, then enable with irq; edge E accepts control
        accx(IO_BASE + 16'h11, 1'b1, 16'd4, 16'h0000);
        accx(IO_BASE + 16'h10, 1'b1, 16'd4, 16'h0000);
        accx(IO_BASE + 16'h12, 1'b1, 16'h0003, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        chk("irq_before_expiry", irq, 1'b0);
        @(posedge clk); #1;
        chk("irq_rise_5", irq, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("irq_held", irq, 1'b1);
        accx(IO_BASE + 16'h12, 1'b1, 16'h8003, 16'h8003);
        chk("irq_set_wins", irq, 1'b1);
        accx(IO_BASE + 16'h12, 1'b1, 16'h8003, 16'h8003);
        chk("irq_cleared", irq, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("irq_before_next", irq, 1'b0);
        @(posedge clk); #1;
        chk("irq_period_5", irq, 1'b1);
        accx(IO_BASE + 16'h10, 1'b0, 16'h0, 16'd4);
`else
        acc(IO_BASE + 16'h12, 1'b1, 16'h0003);
        accx(IO_BASE + 16'h12, 1'b0, 16'h0, 16'h0000);
        irq_hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (irq) irq_hi++;
        end
        chk("irq_tied_low", 32'(irq_hi), 32'd0);
        @(posedge clk); #1;
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("rom_wait0_no_hold", 32'(hold0_hi), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
